icache_refill: RTL and testbench



---
 rtl/config_pkg.sv | 47 ++++
 rtl/icache_refill.sv | 173 +++++++++++++++++
 tb/tb_icache_refill.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/config_pkg.sv
// ============================================================================
// Module      : config_pkg
// Description : Shared cache configuration record, sizing helpers and the
//               refill request type used by the icache refill engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package config_pkg;

    typedef struct packed {
        int unsigned PLEN;
        int unsigned ICACHE_LINE_WIDTH;
        int unsigned ICACHE_OFFSET_WIDTH;
        int unsigned ICACHE_INDEX_WIDTH;
        int unsigned ICACHE_TAG_WIDTH;
        int unsigned ICACHE_SET_ASSOC_WIDTH;
    } cfg_t;

    localparam cfg_t EmptyCfg = '{
        PLEN:                   32,
        ICACHE_LINE_WIDTH:      256,
        ICACHE_OFFSET_WIDTH:    5,
        ICACHE_INDEX_WIDTH:     6,
        ICACHE_TAG_WIDTH:       21,
        ICACHE_SET_ASSOC_WIDTH: 2
    };

    function automatic int unsigned icache_beats(input cfg_t cfg, input int unsigned bus_width);
        return cfg.ICACHE_LINE_WIDTH / bus_width;
    endfunction

    // A single-beat line still needs a 1-bit slot/counter to keep vectors legal.
    function automatic int unsigned icache_slot_width(input cfg_t cfg, input int unsigned bus_width);
        int unsigned beats;
        beats = icache_beats(cfg, bus_width);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    typedef struct packed {
        logic [63:0] paddr;
        logic [7:0]  way;
    } icache_refill_req_t;

endpackage

`default_nettype wire

// File: rtl/icache_refill.sv
// ============================================================================
// Module      : icache_refill
// Description : Single-outstanding icache miss refill engine: one burst read,
//               beat assembly into a line, line write handshake. Define
//               ICACHE_REFILL_CWF_EN for critical-word-first wrapping bursts.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_refill
    import config_pkg::*;
#(
    parameter cfg_t        Cfg       = EmptyCfg,
    parameter int unsigned BUS_WIDTH = 64
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  miss_valid_i,
    output logic                                  miss_ready_o,
    input  logic [Cfg.PLEN-1:0]                   miss_paddr_i,
    input  logic [Cfg.ICACHE_SET_ASSOC_WIDTH-1:0] miss_way_i,
    input  logic                                  kill_i,
    output logic                                  mem_req_valid_o,
    input  logic                                  mem_req_ready_i,
    output logic [Cfg.PLEN-1:0]                   mem_req_addr_o,
    output logic [3:0]                            mem_req_len_o,
    input  logic                                  mem_rsp_valid_i,
    output logic                                  mem_rsp_ready_o,
    input  logic [BUS_WIDTH-1:0]                  mem_rsp_data_i,
    input  logic                                  mem_rsp_last_i,
    input  logic                                  mem_rsp_err_i,
    output logic                                  refill_valid_o,
    input  logic                                  refill_ready_i,
    output logic [Cfg.ICACHE_INDEX_WIDTH-1:0]     refill_index_o,
    output logic [Cfg.ICACHE_TAG_WIDTH-1:0]       refill_tag_o,
    output logic [Cfg.ICACHE_SET_ASSOC_WIDTH-1:0] refill_way_o,
    output logic [Cfg.ICACHE_LINE_WIDTH-1:0]      refill_data_o,
    output logic                                  refill_err_o
);

    localparam int unsigned PLEN   = Cfg.PLEN;
    localparam int unsigned LINE_W = Cfg.ICACHE_LINE_WIDTH;
    localparam int unsigned OFFSET = Cfg.ICACHE_OFFSET_WIDTH;
    localparam int unsigned INDEX  = Cfg.ICACHE_INDEX_WIDTH;
    localparam int unsigned TAG    = Cfg.ICACHE_TAG_WIDTH;
    localparam int unsigned WAY_W  = Cfg.ICACHE_SET_ASSOC_WIDTH;
    localparam int unsigned BEATS  = icache_beats(Cfg, BUS_WIDTH);
    localparam int unsigned SW     = icache_slot_width(Cfg, BUS_WIDTH);

`ifdef ICACHE_REFILL_CWF_EN
    localparam int unsigned ALIGN_BITS = $clog2(BUS_WIDTH / 8);
`else
    localparam int unsigned ALIGN_BITS = OFFSET;
`endif
    localparam logic [PLEN-1:0] ALIGN_MASK = PLEN'((64'd1 << ALIGN_BITS) - 64'd1);
    localparam logic [SW-1:0]   SLOT_MASK  = SW'(BEATS - 1);
    localparam logic [SW-1:0]   LAST_CNT   = SW'(BEATS - 1);

    if (BEATS < 1 || BEATS > 16 || (BEATS & (BEATS - 1)) != 0 ||
        BEATS * BUS_WIDTH != LINE_W) begin : g_bad_beats
        $error("icache_refill: LINE_WIDTH/BUS_WIDTH must be a power of two in 1..16");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_RECV  = 2'd2,
        S_WRITE = 2'd3
    } refill_state_e;

    refill_state_e     state_q;
    logic [PLEN-1:0]   paddr_q;
    logic [WAY_W-1:0]  way_q;
    logic [SW-1:0]     cnt_q;
    logic              err_q;
    logic              killed_q;
    logic [LINE_W-1:0] line_q;
    logic              miss_ready_q;
    logic              mem_req_valid_q;
    logic              mem_rsp_ready_q;
    logic              refill_valid_q;

    logic [SW-1:0]     beat_slot;
    logic              beat_end;
    logic              beat_proto_err;

`ifdef ICACHE_REFILL_CWF_EN
    logic [SW-1:0] start_slot;
    assign start_slot = SW'(paddr_q >> ALIGN_BITS) & SLOT_MASK;
    assign beat_slot  = (start_slot + cnt_q) & SLOT_MASK;
`else
    assign beat_slot  = cnt_q;
`endif

    // A burst ends on last or on the final expected beat; disagreement poisons it.
    assign beat_end       = mem_rsp_last_i | (cnt_q == LAST_CNT);
    assign beat_proto_err = mem_rsp_last_i ^ (cnt_q == LAST_CNT);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= S_IDLE;
            paddr_q         <= '0;
            way_q           <= '0;
            cnt_q           <= '0;
            err_q           <= 1'b0;
            killed_q        <= 1'b0;
            line_q          <= '0;
            miss_ready_q    <= 1'b1;
            mem_req_valid_q <= 1'b0;
            mem_rsp_ready_q <= 1'b0;
            refill_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (miss_valid_i) begin
                        paddr_q         <= miss_paddr_i;
                        way_q           <= miss_way_i;
                        cnt_q           <= '0;
                        err_q           <= 1'b0;
                        killed_q        <= 1'b0;
                        miss_ready_q    <= 1'b0;
                        mem_req_valid_q <= 1'b1;
                        state_q         <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (kill_i) killed_q <= 1'b1;
                    if (mem_req_ready_i) begin
                        mem_req_valid_q <= 1'b0;
                        mem_rsp_ready_q <= 1'b1;
                        state_q         <= S_RECV;
                    end
                end
                S_RECV: begin
                    if (kill_i) killed_q <= 1'b1;
                    if (mem_rsp_valid_i) begin
                        line_q[beat_slot*BUS_WIDTH +: BUS_WIDTH] <= mem_rsp_data_i;
                        cnt_q <= cnt_q + SW'(1);
                        err_q <= err_q | mem_rsp_err_i | beat_proto_err;
                        if (beat_end) begin
                            mem_rsp_ready_q <= 1'b0;
                            refill_valid_q  <= !(killed_q || kill_i);
                            state_q         <= S_WRITE;
                        end
                    end
                end
                default: begin
                    // A killed line is never offered, so it retires immediately.
                    if (!refill_valid_q || refill_ready_i) begin
                        refill_valid_q <= 1'b0;
                        miss_ready_q   <= 1'b1;
                        state_q        <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign miss_ready_o    = miss_ready_q;
    assign mem_req_valid_o = mem_req_valid_q;
    assign mem_req_addr_o  = paddr_q & ~ALIGN_MASK;
    assign mem_req_len_o   = 4'(BEATS - 1);
    assign mem_rsp_ready_o = mem_rsp_ready_q;
    assign refill_valid_o  = refill_valid_q;
    assign refill_index_o  = paddr_q[OFFSET +: INDEX];
    assign refill_tag_o    = paddr_q[PLEN-1 -: TAG];
    assign refill_way_o    = way_q;
    assign refill_data_o   = line_q;
    assign refill_err_o    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_icache_refill.sv
// ============================================================================
// Module      : tb_icache_refill
// Description : Directed self-checking bench for icache_refill (256-bit line,
//               64-bit bus, PLEN 32); honours ICACHE_REFILL_CWF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icache_refill;
    import config_pkg::*;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         miss_valid_i = 1'b0;
    logic         miss_ready_o;
    logic [31:0]  miss_paddr_i = '0;
    logic [1:0]   miss_way_i = '0;
    logic         kill_i = 1'b0;
    logic         mem_req_valid_o;
    logic         mem_req_ready_i = 1'b0;
    logic [31:0]  mem_req_addr_o;
    logic [3:0]   mem_req_len_o;
    logic         mem_rsp_valid_i = 1'b0;
    logic         mem_rsp_ready_o;
    logic [63:0]  mem_rsp_data_i = '0;
    logic         mem_rsp_last_i = 1'b0;
    logic         mem_rsp_err_i = 1'b0;
    logic         refill_valid_o;
    logic         refill_ready_i = 1'b0;
    logic [5:0]   refill_index_o;
    logic [20:0]  refill_tag_o;
    logic [1:0]   refill_way_o;
    logic [255:0] refill_data_o;
    logic         refill_err_o;

    int checks = 0;
    int errors = 0;

    icache_refill #(.Cfg(EmptyCfg), .BUS_WIDTH(64)) u_dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .miss_valid_i    (miss_valid_i),
        .miss_ready_o    (miss_ready_o),
        .miss_paddr_i    (miss_paddr_i),
        .miss_way_i      (miss_way_i),
        .kill_i          (kill_i),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_req_len_o   (mem_req_len_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_ready_o (mem_rsp_ready_o),
        .mem_rsp_data_i  (mem_rsp_data_i),
        .mem_rsp_last_i  (mem_rsp_last_i),
        .mem_rsp_err_i   (mem_rsp_err_i),
        .refill_valid_o  (refill_valid_o),
        .refill_ready_i  (refill_ready_i),
        .refill_index_o  (refill_index_o),
        .refill_tag_o    (refill_tag_o),
        .refill_way_o    (refill_way_o),
        .refill_data_o   (refill_data_o),
        .refill_err_o    (refill_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [63:0] dat(input int t, input int k);
        return {32'hDA7A0000 | 32'(t), 32'h0BEE0000 | 32'(k)};
    endfunction

    task automatic issue_miss(input logic [31:0] a, input logic [1:0] w);
        miss_valid_i = 1'b1;
        miss_paddr_i = a;
        miss_way_i   = w;
        step();
        miss_valid_i = 1'b0;
    endtask

    task automatic accept_req(input string tag, input logic [31:0] exp_addr);
        check({tag, "_req_valid"}, 256'(mem_req_valid_o), 256'(1));
        check({tag, "_req_addr"}, 256'(mem_req_addr_o), 256'(exp_addr));
        check({tag, "_req_len"}, 256'(mem_req_len_o), 256'(3));
        mem_req_ready_i = 1'b1;
        step();
        mem_req_ready_i = 1'b0;
        check({tag, "_rsp_ready"}, 256'(mem_rsp_ready_o), 256'(1));
    endtask

    task automatic beat(input logic [63:0] d, input logic e, input logic l);
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = d;
        mem_rsp_err_i   = e;
        mem_rsp_last_i  = l;
        step();
        mem_rsp_valid_i = 1'b0;
        mem_rsp_err_i   = 1'b0;
        mem_rsp_last_i  = 1'b0;
    endtask

    task automatic finish_write();
        refill_ready_i = 1'b1;
        step();
        refill_ready_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] exp_line;

        step();
        step();
        check("rst_miss_ready", 256'(miss_ready_o), 256'(1));
        check("rst_req_valid", 256'(mem_req_valid_o), 256'(0));
        check("rst_rsp_ready", 256'(mem_rsp_ready_o), 256'(0));
        check("rst_refill_valid", 256'(refill_valid_o), 256'(0));
        check("rst_data", refill_data_o, 256'(0));
        rst_i = 1'b0;
        step();

        // Basic refill
        issue_miss(32'h8000_1040, 2'd2);
        check("basic_miss_ready", 256'(miss_ready_o), 256'(0));
        accept_req("basic", 32'h8000_1040);
        for (int k = 0; k < 4; k++) beat(dat(1, k), 1'b0, k == 3);
        check("basic_valid", 256'(refill_valid_o), 256'(1));
        check("basic_index", 256'(refill_index_o), 256'(6'h02));
        check("basic_tag", 256'(refill_tag_o), 256'(21'h100002));
        check("basic_way", 256'(refill_way_o), 256'(2));
        check("basic_data", refill_data_o, {dat(1, 3), dat(1, 2), dat(1, 1), dat(1, 0)});
        check("basic_err", 256'(refill_err_o), 256'(0));
        finish_write();
        check("basic_back_idle", 256'(miss_ready_o), 256'(1));
        check("basic_valid_drop", 256'(refill_valid_o), 256'(0));

        // Unaligned miss: wrapping burst in the CWF build, line-aligned otherwise
        issue_miss(32'h8000_1050, 2'd1);
`ifdef ICACHE_REFILL_CWF_EN
        accept_req("cwf", 32'h8000_1050);
        exp_line = {dat(2, 1), dat(2, 0), dat(2, 3), dat(2, 2)};
`else
        accept_req("cwf", 32'h8000_1040);
        exp_line = {dat(2, 3), dat(2, 2), dat(2, 1), dat(2, 0)};
`endif
        for (int k = 0; k < 4; k++) beat(dat(2, k), 1'b0, k == 3);
        check("cwf_valid", 256'(refill_valid_o), 256'(1));
        check("cwf_data", refill_data_o, exp_line);
        finish_write();

        // Error on beat 1: all beats still drained, line poisoned
        issue_miss(32'h8000_0000, 2'd0);
        accept_req("errb", 32'h8000_0000);
        beat(dat(3, 0), 1'b0, 1'b0);
        beat(dat(3, 1), 1'b1, 1'b0);
        check("errb_still_recv", 256'(mem_rsp_ready_o), 256'(1));
        beat(dat(3, 2), 1'b0, 1'b0);
        beat(dat(3, 3), 1'b0, 1'b1);
        check("errb_valid", 256'(refill_valid_o), 256'(1));
        check("errb_err", 256'(refill_err_o), 256'(1));
        finish_write();

        // Early last on beat 2
        issue_miss(32'h8000_0100, 2'd3);
        accept_req("early", 32'h8000_0100);
        beat(dat(4, 0), 1'b0, 1'b0);
        beat(dat(4, 1), 1'b0, 1'b0);
        beat(dat(4, 2), 1'b0, 1'b1);
        check("early_valid", 256'(refill_valid_o), 256'(1));
        check("early_rsp_ready", 256'(mem_rsp_ready_o), 256'(0));
        check("early_err", 256'(refill_err_o), 256'(1));
        finish_write();

        // Fourth beat without last
        issue_miss(32'h8000_0200, 2'd0);
        accept_req("nolast", 32'h8000_0200);
        for (int k = 0; k < 4; k++) beat(dat(5, k), 1'b0, 1'b0);
        check("nolast_valid", 256'(refill_valid_o), 256'(1));
        check("nolast_err", 256'(refill_err_o), 256'(1));
        finish_write();

        // Kill during RECV
        issue_miss(32'h8000_0300, 2'd1);
        accept_req("kill", 32'h8000_0300);
        beat(dat(6, 0), 1'b0, 1'b0);
        kill_i = 1'b1;
        step();
        kill_i = 1'b0;
        check("kill_still_recv", 256'(mem_rsp_ready_o), 256'(1));
        for (int k = 1; k < 4; k++) beat(dat(6, k), 1'b0, k == 3);
        check("kill_no_valid", 256'(refill_valid_o), 256'(0));
        check("kill_not_idle_yet", 256'(miss_ready_o), 256'(0));
        step();
        check("kill_idle", 256'(miss_ready_o), 256'(1));
        check("kill_no_valid2", 256'(refill_valid_o), 256'(0));

        // Backpressure on the line write, with a competing miss and a late kill
        issue_miss(32'h8000_2FE0, 2'd1);
        accept_req("bp", 32'h8000_2FE0);
        for (int k = 0; k < 4; k++) beat(dat(7, k), 1'b0, k == 3);
        miss_valid_i = 1'b1;
        miss_paddr_i = 32'h9000_0000;
        for (int c = 0; c < 5; c++) begin
            kill_i = (c == 2);
            check("bp_valid", 256'(refill_valid_o), 256'(1));
            check("bp_data", refill_data_o, {dat(7, 3), dat(7, 2), dat(7, 1), dat(7, 0)});
            check("bp_index", 256'(refill_index_o), 256'(6'h3F));
            check("bp_tag", 256'(refill_tag_o), 256'(21'h100005));
            check("bp_no_miss", 256'(miss_ready_o), 256'(0));
            check("bp_no_req", 256'(mem_req_valid_o), 256'(0));
            step();
        end
        kill_i         = 1'b0;
        miss_valid_i   = 1'b0;
        refill_ready_i = 1'b1;
        check("bp_valid_end", 256'(refill_valid_o), 256'(1));
        step();
        refill_ready_i = 1'b0;
        check("bp_idle", 256'(miss_ready_o), 256'(1));
        check("bp_no_second_req", 256'(mem_req_valid_o), 256'(0));

        // Reset pulsed in RECV
        issue_miss(32'h8000_0400, 2'd2);
        accept_req("rst", 32'h8000_0400);
        beat(dat(8, 0), 1'b0, 1'b0);
        rst_i = 1'b1;
        step();
        check("rst_mid_rsp_ready", 256'(mem_rsp_ready_o), 256'(0));
        check("rst_mid_miss_ready", 256'(miss_ready_o), 256'(1));
        check("rst_mid_data", refill_data_o, 256'(0));
        rst_i = 1'b0;
        step();
        check("rst_mid_idle", 256'(miss_ready_o), 256'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
